// File: rtl/hilo_mul_ctrl_pkg.sv
// hilo_mul_ctrl shared package: op codes, FSM states, widths.
// Used by hilo_mul_ctrl and hilo_sign_fix.
package hilo_mul_ctrl_pkg;

    localparam int W32 = 32;
    localparam int W64 = 64;

    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MULT  = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_sign_fix.sv
// Sign-magnitude helpers for signed MULT: operand magnitudes in,
// two's-complement negate of the unsigned product out.
module hilo_sign_fix
    import hilo_mul_ctrl_pkg::*;
(
    input  logic [W32-1:0] i_a,
    input  logic [W32-1:0] i_b,
    input  logic           i_signed,
    input  logic           i_neg,
    input  logic [W64-1:0] i_z,
    output logic [W32-1:0] o_a,
    output logic [W32-1:0] o_b,
    output logic [W64-1:0] o_z
);

    // Magnitudes only for signed ops; 0x80000000 maps onto itself.
    always_comb begin
        o_a = (i_signed && i_a[W32-1]) ? (~i_a + 32'd1) : i_a;
        o_b = (i_signed && i_b[W32-1]) ? (~i_b + 32'd1) : i_b;
    end

    // Negate the product when exactly one operand was negative.
    always_comb begin
        o_z = i_neg ? (~i_z + 64'd1) : i_z;
    end

endmodule

// File: rtl/hilo_mul_ctrl.sv
// HI/LO owner and multicycle sequencer for the external 32x32 multiplier.
// Optional signed MULT path enabled by defining HILO_SIGNED_EN.
module hilo_mul_ctrl
    import hilo_mul_ctrl_pkg::*;
#(
    parameter int unsigned MUL_WAIT = 2
)
(
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [2:0]     i_op,
    input  logic [W32-1:0] i_a,
    input  logic [W32-1:0] i_b,
    output logic [W32-1:0] o_mul_a,
    output logic [W32-1:0] o_mul_b,
    input  logic [W64-1:0] i_mul_z,
    output logic [W32-1:0] o_hi,
    output logic [W32-1:0] o_lo,
    output logic           o_busy,
    output logic           o_done
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_WAIT - 1);

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [W32-1:0] r_mul_a;
    logic [W32-1:0] r_mul_b;
    logic [W32-1:0] r_hi;
    logic [W32-1:0] r_lo;
    logic           r_busy;
    logic           r_done;

    logic [W32-1:0] w_op_a;
    logic [W32-1:0] w_op_b;
    logic [W64-1:0] w_prod;

`ifdef HILO_SIGNED_EN
    logic r_neg;
    logic w_is_mult;

    assign w_is_mult = (i_op == OP_MULT);

    hilo_sign_fix u_sign_fix (
        .i_a      (i_a),
        .i_b      (i_b),
        .i_signed (w_is_mult),
        .i_neg    (r_neg),
        .i_z      (i_mul_z),
        .o_a      (w_op_a),
        .o_b      (w_op_b),
        .o_z      (w_prod)
    );
`else
    assign w_op_a = i_a;
    assign w_op_b = i_b;
    assign w_prod = i_mul_z;
`endif

    // Sequencer: accept in IDLE, count settle cycles, write HI/LO in WB.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef HILO_SIGNED_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        case (i_op)
                            OP_MULTU, OP_MULT: begin
                                r_mul_a <= w_op_a;
                                r_mul_b <= w_op_b;
                                r_cnt   <= CNT_INIT;
                                r_busy  <= 1'b1;
                                r_state <= CALC;
`ifdef HILO_SIGNED_EN
                                r_neg   <= w_is_mult &
                                           (i_a[W32-1] ^ i_b[W32-1]);
`endif
                            end
                            OP_MTHI: r_hi <= i_a;
                            OP_MTLO: r_lo <= i_a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= WB;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WB: begin
                    {r_hi, r_lo} <= w_prod;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_mul_a = r_mul_a;
    assign o_mul_b = r_mul_b;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule
